multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to execute one operation.
REQ-005 The block SHALL have port ALUOperation, input, 4 bits: operation code, 0 AND, 1 OR, 2 NOR, 3 ADD, 4 SUB, 5 LUI, 6 SLL, 7 SRL; 8-15 invalid.
REQ-006 The block SHALL have port Shamt, input, 1 bit: for shift codes, 1 selects shamt as the shift amount and 0 selects A[4:0].
REQ-007 The block SHALL have port A, input, DATA_WIDTH bits: first operand (rs).
REQ-008 The block SHALL have port B, input, DATA_WIDTH bits: second operand (rt or immediate); it is the shifted operand.
REQ-009 The block SHALL have port shamt, input, 5 bits: instruction shift-amount field.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an accepted operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid ALUResult.
REQ-012 The block SHALL have port ALUResult, output, DATA_WIDTH bits: registered result.
REQ-013 The block SHALL have port Zero, output, 1 bit: registered flag, high when ALUResult equals 0.
REQ-014 The block SHALL have port invalid, output, 1 bit: registered flag, high when the last completed code was 8-15.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EXEC and SHIFT.
REQ-016 The FSM SHALL accept start only in IDLE, latching ALUOperation, Shamt, A, B and the effective shift amount at the accepting edge.
REQ-017 The FSM SHALL ignore start while busy is high.
REQ-018 After acceptance, codes 6 and 7 SHALL go to SHIFT and all other codes SHALL go to EXEC.
REQ-019 busy SHALL be high in EXEC and SHIFT and low in IDLE.
REQ-020 EXEC SHALL last one cycle and then write ALUResult, Zero and invalid, pulse done, and return to IDLE.
REQ-021 Latency for non-shift codes SHALL be 1: if start is accepted at edge k, done is high for exactly the cycle after edge k+1.
REQ-022 SHIFT SHALL shift the latched B by one bit per cycle: logical left for SLL, logical right with zero fill for SRL.
REQ-023 The shift counter SHALL be 5 bits, loaded with the amount, and decremented once per shifted bit.
REQ-024 SHIFT SHALL exit when the counter is 0, writing the result and pulsing done; shift latency is max(amount,1), with amount 0 returning B unchanged after 1 cycle.
REQ-025 Results: AND A&B; OR A|B; NOR ~(A|B); ADD A+B; SUB A-B; LUI {B[15:0],16'b0}.
REQ-026 ADD and SUB results SHALL be modulo 2^DATA_WIDTH, with no carry or overflow output.
REQ-027 Codes 8-15 SHALL produce ALUResult 0, Zero 1 and invalid 1, with latency 1.
REQ-028 Shamt SHALL be ignored for non-shift codes.
REQ-029 ALUResult, Zero and invalid SHALL hold their values between done pulses and change only in the cycle done is high.
REQ-030 The FSM SHALL be in IDLE in the same cycle that done is high, and a start in that cycle SHALL be accepted, giving back-to-back operations.
REQ-031 Input changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-032 Asserting reset low SHALL immediately force IDLE, busy 0, done 0, ALUResult 0, Zero 1, invalid 0, and clear the shift counter and latched operands.
REQ-033 Reset during EXEC or SHIFT SHALL discard the in-flight operation with no done pulse; the first start after reset releases is accepted normally.

Verification
REQ-034 The bench SHALL check: ADD, A=0x0000_0005, B=0x0000_0003, start pulse -> done 1 cycle later, ALUResult 0x0000_0008, Zero 0, busy high for 1 cycle.
REQ-035 The bench SHALL check: SUB, A=B=0x1234_5678 -> ALUResult 0, Zero 1; SUB, A=0, B=1 -> ALUResult 0xFFFF_FFFF.
REQ-036 The bench SHALL check: SLL, Shamt=1, shamt=4, B=0x0000_000F -> done 4 cycles after accept, ALUResult 0x0000_00F0; start during busy is ignored.
REQ-037 The bench SHALL check: SRL, Shamt=0, A=0x0000_0000 (amount 0), B=0x8000_0000 -> done after 1 cycle, ALUResult 0x8000_0000; then SRL, Shamt=0, A[4:0]=31 -> ALUResult 0x0000_0001.
REQ-038 The bench SHALL check: LUI, B=0x0000_ABCD -> ALUResult 0xABCD_0000; code 9 -> ALUResult 0, Zero 1, invalid 1.
REQ-039 The bench SHALL check: SLL with shamt=20, reset asserted after 5 SHIFT cycles -> outputs at reset values, no done pulse; a following ADD, A=1, B=1 -> ALUResult 2.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: logic/arith ops in one EXEC cycle, shifts one bit per cycle.
// Latency: 1 cycle for non-shift codes, max(amount,1) cycles for SLL/SRL.
// Backpressure: start is accepted only while idle; busy high means start is ignored.
module multicycle_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            ALUOperation,
    input  logic                  Shamt,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            shamt,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  invalid
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_NOR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_LUI = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              op_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [4:0]              cnt;

    logic [4:0]              eff_amt;
    logic                    start_is_shift;
    logic [DATA_WIDTH-1:0]   lui_val;
    logic [DATA_WIDTH-1:0]   exec_res;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic [DATA_WIDTH-1:0]   fin_val;

    assign eff_amt        = Shamt ? shamt : A[4:0];
    assign start_is_shift = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
    assign lui_val        = {{(DATA_WIDTH-16){1'b0}}, b_q[15:0]} << 16;
    assign shift_next     = (op_q == OP_SRL) ? (b_q >> 1) : (b_q << 1);
    assign fin_val        = (cnt == 5'd0) ? b_q : shift_next;

    always_comb begin
        exec_res = '0;
        case (op_q)
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_NOR:  exec_res = ~(a_q | b_q);
            OP_ADD:  exec_res = a_q + b_q;
            OP_SUB:  exec_res = a_q - b_q;
            OP_LUI:  exec_res = lui_val;
            default: exec_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            invalid   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= ALUOperation;
                        a_q   <= A;
                        b_q   <= B;
                        cnt   <= eff_amt;
                        busy  <= 1'b1;
                        state <= start_is_shift ? SHIFT : EXEC;
                    end
                end
                EXEC: begin
                    ALUResult <= exec_res;
                    Zero      <= (exec_res == '0);
                    invalid   <= op_q[3];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                SHIFT: begin
                    if (cnt != 5'd0) begin
                        b_q <= shift_next;
                        cnt <= cnt - 5'd1;
                    end
                    // Finish on the edge that performs the last shift so latency equals the amount
                    if (cnt <= 5'd1) begin
                        ALUResult <= fin_val;
                        Zero      <= (fin_val == '0);
                        invalid   <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
